// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - framed byte-stream loader that programs the instruction ROM and holds the core in reset
// Optional trailing XOR checksum byte and CSUM state: define ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
  parameter int          ROM_ADDR_WIDTH = 12,
  parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        rom_wr_en_o,
  output logic [31:0] rom_wr_addr_o,
  output logic [31:0] rom_wr_data_o,
  output logic        cpu_hold_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam int          WIDX_W       = ROM_ADDR_WIDTH - 1;
  localparam logic [16:0] DEPTH        = 17'(1) << (ROM_ADDR_WIDTH - 2);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA,
`ifdef ROM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE, ERR
  } state_t;

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_t PAYLOAD_END = CSUM;
`else
  localparam state_t PAYLOAD_END = DONE;
`endif

  state_t              state, state_next;
  logic [7:0]          len_lo;
  logic [15:0]         word_cnt;
  logic [WIDX_W-1:0]   word_idx;
  logic [1:0]          lane;
  logic [23:0]         word_buf;
  logic [23:0]         idle_cnt;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  logic accept, is_sync, in_frame, timed_out, start_frame, wr_fire;
  logic [16:0] len_full;

  assign accept    = rx_valid_i & rx_ready_o;
  assign is_sync   = accept && (rx_data_i == SYNC_BYTE);
  assign in_frame  = (state != IDLE) && (state != DONE) && (state != ERR);
  assign timed_out = in_frame && !accept && (idle_cnt == TIMEOUT_LAST);
  assign len_full  = {1'b0, rx_data_i, len_lo};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    wr_fire     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (is_sync) begin
          start_frame = 1'b1;
          state_next  = LEN_LO;
        end
      end
      LEN_LO: if (accept) state_next = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (len_full > DEPTH)       state_next = ERR;
          else if (len_full == 17'd0) state_next = PAYLOAD_END;
          else                        state_next = DATA;
        end
      end
      DATA: begin
        if (accept && lane == 2'd3) begin
          wr_fire = 1'b1;
          if ((17'(word_idx) + 17'd1) == {1'b0, word_cnt}) state_next = PAYLOAD_END;
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      CSUM: if (accept) state_next = (rx_data_i == csum) ? DONE : ERR;
`endif
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timed_out) state_next = ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ready_o    <= 1'b0;
      rom_wr_en_o   <= 1'b0;
      rom_wr_addr_o <= ROM_BASE;
      rom_wr_data_o <= 32'h0;
      cpu_hold_o    <= 1'b1;
      load_done_o   <= 1'b0;
      load_err_o    <= 1'b0;
      len_lo        <= 8'h0;
      word_cnt      <= 16'h0;
      word_idx      <= '0;
      lane          <= 2'd0;
      word_buf      <= 24'h0;
      idle_cnt      <= 24'h0;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum          <= 8'h0;
`endif
    end else begin
      rx_ready_o  <= 1'b1;
      rom_wr_en_o <= wr_fire;

      if (accept || !in_frame) idle_cnt <= 24'h0;
      else                     idle_cnt <= idle_cnt + 24'd1;

      if (start_frame) begin
        load_done_o <= 1'b0;
        load_err_o  <= 1'b0;
        cpu_hold_o  <= 1'b1;
        word_idx    <= '0;
        lane        <= 2'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
        csum        <= 8'h0;
`endif
      end else begin
        if (state == DONE) begin
          load_done_o <= 1'b1;
          cpu_hold_o  <= 1'b0;
        end
        if (state == ERR) load_err_o <= 1'b1;
      end

      if (state == LEN_LO && accept) len_lo   <= rx_data_i;
      if (state == LEN_HI && accept) word_cnt <= {rx_data_i, len_lo};

      // Bytes shift in from the top so the first three land little-endian in word_buf.
      if (state == DATA && accept) begin
        lane     <= lane + 2'd1;
        word_buf <= {rx_data_i, word_buf[23:8]};
`ifdef ROM_LOADER_CHECKSUM_EN
        csum     <= csum ^ rx_data_i;
`endif
      end

      if (wr_fire) begin
        rom_wr_data_o <= {rx_data_i, word_buf};
        rom_wr_addr_o <= ROM_BASE + 32'({word_idx, 2'b00});
        word_idx      <= word_idx + WIDX_W'(1);
      end
    end
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Boot-time controller that programs the instruction ROM's write port from a byte stream, e.g. a UART receiver.
- Sits between the RX byte interface and the ROM write side (wr_en_i/wr_addr_i/wr_data_i).
- Holds the core in reset while a program image is loaded.
- Parses a framed image (sync, length, payload, optional checksum), packs little-endian bytes into 32-bit instructions and issues one ROM write per word.

Parameters:
- ROM_ADDR_WIDTH, 12: ROM byte-address width; depth = 2^(ROM_ADDR_WIDTH-2) words.
- ROM_BASE, 32'h0000_0000: byte address of word 0.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 1_000_000: max idle cycles between accepted bytes inside a frame; 24-bit counter.

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset
- rx_valid_i  in  1  byte available
- rx_data_i  in  8  byte value
- rx_ready_o  out  1  byte accepted when rx_valid_i & rx_ready_o
- rom_wr_en_o  out  1  ROM write strobe, one cycle per word
- rom_wr_addr_o  out  32  ROM write byte address
- rom_wr_data_o  out  32  ROM write instruction
- cpu_hold_o  out  1  core reset request, 1 = hold
- load_done_o  out  1  last frame loaded successfully
- load_err_o  out  1  last frame aborted

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: state=IDLE, rx_ready_o=0, rom_wr_en_o=0, rom_wr_addr_o=ROM_BASE, rom_wr_data_o=0, cpu_hold_o=1, load_done_o=0, load_err_o=0.
- Reset mid-frame: abandons the frame with no further writes.
- rx_ready_o: 1 in every state after reset. The block never stalls, because the ROM write is single-cycle.
- States:
  - IDLE: discard bytes until SYNC_BYTE, then clear load_err_o and load_done_o, assert cpu_hold_o, go to LEN_LO.
  - LEN_LO, LEN_HI: capture the 16-bit word count N, little-endian.
    - After LEN_HI, N > depth → ERR.
    - N == 0 → CSUM (or DONE without the feature).
    - Otherwise → DATA.
  - DATA:
    - Byte lane = 2-bit byte counter; lane 0 = bits [7:0].
    - On the 4th byte, the registered outputs in the next cycle are rom_wr_en_o=1, rom_wr_data_o=packed word, rom_wr_addr_o=ROM_BASE + 4*word_idx.
    - word_idx increments; after word N-1 → CSUM (or DONE).
    - Write latency is one cycle after the 4th accepted byte.
  - CSUM (feature only): the next byte is compared with the XOR of all payload bytes. Match → DONE; mismatch → ERR.
  - DONE: load_done_o=1, cpu_hold_o=0, one cycle after entry. A SYNC_BYTE here starts a new frame (hold reasserted next cycle); other bytes are discarded.
  - ERR: load_err_o=1, cpu_hold_o stays 1, next cycle → IDLE. load_err_o is sticky until the next SYNC_BYTE.
- Timeout: in LEN_LO..CSUM the idle counter resets on each accepted byte; reaching TIMEOUT_CYCLES → ERR. The counter is not active in IDLE or DONE.
- Partial-data aborts (timeout, reset): words already written stay in the ROM; no partial word is written.
- rom_wr_addr_o and rom_wr_data_o hold their last values when rom_wr_en_o=0.
- word_idx width: ROM_ADDR_WIDTH-1 bits, so word_idx == depth never wraps before the compare.

Optional Feature:
- Macro ROM_LOADER_CHECKSUM_EN.
  - Defined: the frame carries a trailing XOR checksum byte and the CSUM state exists. load_done_o is asserted only on a checksum match; a mismatch gives ERR.
  - Undefined: no checksum byte and no CSUM state. DONE is entered in the cycle after the last word's write strobe. A byte following the payload is treated as an ordinary byte in DONE.

Test Plan:
- Reset, then idle 10 cycles → cpu_hold_o=1, rom_wr_en_o=0, load_done_o=0, rx_ready_o=1.
- Frame A5 02 00 | 13 00 00 00 | 6F 00 00 00 | csum 7C → writes (0x0, 0x00000013) and (0x4, 0x0000006F), one strobe each. Then load_done_o=1 and cpu_hold_o=0.
- Same frame with csum 00 (feature on) → load_err_o=1, cpu_hold_o=1, state IDLE. A resend of the correct frame then gives load_done_o=1 and clears load_err_o.
- Length 0x0401 with ROM_ADDR_WIDTH=12 (depth 1024) → ERR after LEN_HI with zero writes. Length 0x0400 with 4096 bytes → the last write goes to address 0xFFC.
- Stop after 2 payload bytes, wait TIMEOUT_CYCLES (set to 100) → ERR at cycle 100 and no partial write.
- Assert rst_n=0 during DATA → next cycle all outputs at reset values. Garbage bytes before A5 and bytes in DONE (non-A5) → ignored, no writes.
